// File: rtl/regfile_writeback_if.sv
// Request/drain bundle for the register file writeback front end.
// master = requesters and port consumer, slave = writeback block.
interface regfile_writeback_if #(
    parameter int DATA_W     = 8,
    parameter int REG_AW     = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_AW-1:0]    alu_dest;
    logic [DATA_W-1:0]    alu_data;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_AW-1:0]    mem_dest;
    logic [DATA_W-1:0]    mem_data;
    logic                 wb_hold;
    logic                 wb_write_enable;
    logic [REG_AW-1:0]    wb_dest_reg;
    logic [DATA_W-1:0]    wb_write_data;
    logic [2**REG_AW-1:0] busy;
    logic [CW-1:0]        fifo_count;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        output wb_hold,
        input  alu_ready, mem_ready,
        input  wb_write_enable, wb_dest_reg, wb_write_data,
        input  busy, fifo_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        input  wb_hold,
        output alu_ready, mem_ready,
        output wb_write_enable, wb_dest_reg, wb_write_data,
        output busy, fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register file writeback front end: mem-priority arbiter,
// in-order FIFO, single write port drain and busy tracking.
module regfile_writeback #(
    parameter int DATA_W     = 8,
    parameter int REG_AW     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              reset_n,
    regfile_writeback_if.slave bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**REG_AW;

    logic [REG_AW-1:0]     dest_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [REG_AW-1:0]     push_dest;
    logic [DATA_W-1:0]     push_data;
    logic [NREG-1:0]       busy_c;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;

    // Pick the single entry to enqueue; memory wins over ALU.
    always_comb begin
        push      = 1'b0;
        push_dest = bus.alu_dest;
        push_data = bus.alu_data;
        if (bus.mem_valid && bus.mem_ready) begin
            push      = 1'b1;
            push_dest = bus.mem_dest;
            push_data = bus.mem_data;
        end else if (bus.alu_valid && bus.alu_ready) begin
            push = 1'b1;
        end
    end

    assign pop = bus.wb_write_enable;

    assign bus.wb_write_enable = !empty && !bus.wb_hold;
    assign bus.wb_dest_reg     = empty ? '0 : dest_q[rd_ptr];
    assign bus.wb_write_data   = empty ? '0 : data_q[rd_ptr];
    assign bus.fifo_count      = count_q;
    assign bus.busy            = busy_c;

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                dest_q[wr_ptr] <= push_dest;
                data_q[wr_ptr] <= push_data;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // A register is busy while any live entry targets it.
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i]) busy_c[dest_q[i]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback against a
// queue-based reference model with directed and random stimulus.
module tb_regfile_writeback;
    typedef struct {
        logic [1:0] d;
        logic [7:0] v;
    } ent_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    ent_t mq[$];

    regfile_writeback_if #(.DATA_W(8), .REG_AW(2), .FIFO_DEPTH(4)) b();

    regfile_writeback #(.DATA_W(8), .REG_AW(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] exp_busy();
        logic [3:0] r;
        r = 4'b0000;
        foreach (mq[i]) r[mq[i].d] = 1'b1;
        return r;
    endfunction

    task automatic advance(output bit ma, output bit aa);
        bit   full;
        bit   pp;
        ent_t me;
        ent_t ae;
        ent_t x;
        full = (mq.size() == 4);
        ma = b.mem_valid && !full;
        aa = !b.mem_valid && b.alu_valid && !full;
        pp = (mq.size() > 0) && !b.wb_hold;
        me = '{b.mem_dest, b.mem_data};
        ae = '{b.alu_dest, b.alu_data};
        @(posedge clk);
        if (pp) x = mq.pop_front();
        if (ma) mq.push_back(me);
        else if (aa) mq.push_back(ae);
        #1;
    endtask

    task automatic step();
        bit ma, aa;
        advance(ma, aa);
    endtask

    task automatic idle_inputs();
        b.alu_valid = 0; b.alu_dest = 0; b.alu_data = 0;
        b.mem_valid = 0; b.mem_dest = 0; b.mem_data = 0;
        b.wb_hold = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        mq.delete();
        #1;
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data,
             b.busy, b.fifo_count} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outs got we=%b d=%0d v=%h busy=%b cnt=%0d exp 0",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data,
                b.busy, b.fifo_count);
        end
        total++;
        if ({b.mem_ready, b.alu_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready got %b%b exp 11", b.mem_ready, b.alu_ready);
        end
        step();
        #2 reset_n = 0;
        #1;
        total++;
        if ({b.wb_write_enable, b.busy, b.fifo_count,
             b.mem_ready, b.alu_ready} !== 10'b0000000011) begin
            bad++;
            $display("FAIL reset_pulse got we=%b busy=%b cnt=%0d rdy=%b%b",
                b.wb_write_enable, b.busy, b.fifo_count, b.mem_ready, b.alu_ready);
        end
        #2 reset_n = 1;
        mq.delete();
        step();
    endtask

    task automatic test_single();
        b.alu_valid = 1; b.alu_dest = 2; b.alu_data = 8'h5A;
        total++;
        if (b.alu_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready got %b exp 1", b.alu_ready);
        end
        step();
        b.alu_valid = 0;
        #1;
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy, b.fifo_count}
            !== {1'b1, 2'd2, 8'h5A, 4'b0100, 3'd1}) begin
            bad++;
            $display("FAIL single_write got we=%b d=%0d v=%h busy=%b cnt=%0d exp 1/2/5a/0100/1",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy, b.fifo_count);
        end
        step();
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy, b.fifo_count}
            !== 18'd0) begin
            bad++;
            $display("FAIL single_drain got we=%b d=%0d v=%h busy=%b cnt=%0d exp 0",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy, b.fifo_count);
        end
    endtask

    task automatic test_priority();
        b.mem_valid = 1; b.mem_dest = 1; b.mem_data = 8'h11;
        b.alu_valid = 1; b.alu_dest = 3; b.alu_data = 8'h33;
        #1;
        total++;
        if ({b.mem_ready, b.alu_ready} !== 2'b10) begin
            bad++; $display("FAIL prio_ready got %b%b exp 10", b.mem_ready, b.alu_ready);
        end
        step();
        b.mem_valid = 0;
        #1;
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.alu_ready}
            !== {1'b1, 2'd1, 8'h11, 1'b1}) begin
            bad++;
            $display("FAIL prio_first got we=%b d=%0d v=%h ar=%b exp 1/1/11/1",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.alu_ready);
        end
        step();
        b.alu_valid = 0;
        #1;
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.fifo_count}
            !== {1'b1, 2'd3, 8'h33, 3'd1}) begin
            bad++;
            $display("FAIL prio_second got we=%b d=%0d v=%h cnt=%0d exp 1/3/33/1",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.fifo_count);
        end
        step();
    endtask

    task automatic test_full();
        logic [1:0] ed [6];
        logic [7:0] ev [6];
        logic [2:0] ec [6];
        ed = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        ev = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77, 8'h00};
        ec = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        b.wb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            b.mem_valid = 1; b.mem_dest = 2'(i); b.mem_data = 8'h10 + 8'(i);
            step();
        end
        b.mem_valid = 0;
        b.alu_valid = 1; b.alu_dest = 2; b.alu_data = 8'h77;
        #1;
        total++;
        if ({b.fifo_count, b.busy, b.mem_ready, b.alu_ready, b.wb_write_enable}
            !== {3'd4, 4'b1111, 3'b000}) begin
            bad++;
            $display("FAIL full_state got cnt=%0d busy=%b rdy=%b%b we=%b exp 4/1111/00/0",
                b.fifo_count, b.busy, b.mem_ready, b.alu_ready, b.wb_write_enable);
        end
        step(); step();
        total++;
        if (b.fifo_count !== 3'd4) begin
            bad++; $display("FAIL full_stall got cnt=%0d exp 4", b.fifo_count);
        end
        b.wb_hold = 0;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data}
                !== {(i < 5), ed[i], ev[i]} || b.fifo_count !== ec[i]) begin
                bad++;
                $display("FAIL full_drain%0d got we=%b d=%0d v=%h cnt=%0d exp %b/%0d/%h/%0d",
                    i, b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.fifo_count,
                    (i < 5), ed[i], ev[i], ec[i]);
            end
            if (i == 1) begin
                total++;
                if (b.alu_ready !== 1'b1) begin
                    bad++; $display("FAIL full_fifth_ready got %b exp 1", b.alu_ready);
                end
            end
            step();
            if (i == 1) b.alu_valid = 0;
            #1;
        end
    endtask

    task automatic test_same_reg();
        b.wb_hold = 1;
        b.alu_valid = 1; b.alu_dest = 0; b.alu_data = 8'hAA;
        step();
        b.alu_data = 8'hBB;
        step();
        b.alu_valid = 0;
        b.wb_hold = 0;
        #1;
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy}
            !== {1'b1, 2'd0, 8'hAA, 4'b0001}) begin
            bad++;
            $display("FAIL same_first got we=%b d=%0d v=%h busy=%b exp 1/0/aa/0001",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy);
        end
        step();
        total++;
        if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy}
            !== {1'b1, 2'd0, 8'hBB, 4'b0001}) begin
            bad++;
            $display("FAIL same_second got we=%b d=%0d v=%h busy=%b exp 1/0/bb/0001",
                b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, b.busy);
        end
        step();
        total++;
        if (b.busy !== 4'b0000) begin
            bad++; $display("FAIL same_busy_clear got %b exp 0000", b.busy);
        end
    endtask

    task automatic test_async_reset();
        b.wb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            b.alu_valid = 1; b.alu_dest = 2'(i + 1); b.alu_data = 8'hC0 + 8'(i);
            step();
        end
        b.alu_valid = 0;
        total++;
        if (b.fifo_count !== 3'd3) begin
            bad++; $display("FAIL arst_pre got cnt=%0d exp 3", b.fifo_count);
        end
        #2 reset_n = 0;
        #1;
        total++;
        if ({b.fifo_count, b.busy, b.wb_write_enable} !== 8'd0) begin
            bad++;
            $display("FAIL arst_now got cnt=%0d busy=%b we=%b exp 0",
                b.fifo_count, b.busy, b.wb_write_enable);
        end
        #2 reset_n = 1;
        mq.delete();
        b.wb_hold = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (b.wb_write_enable !== 1'b0) begin
                bad++; $display("FAIL arst_stale%0d got we=%b exp 0", i, b.wb_write_enable);
            end
        end
    endtask

    task automatic test_random();
        bit         ma, aa;
        logic       e_we;
        logic [1:0] e_d;
        logic [7:0] e_v;
        logic [3:0] e_b;
        logic [2:0] e_c;
        ma = 1; aa = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!b.mem_valid || ma) begin
                b.mem_valid = ($urandom_range(0, 2) == 0);
                b.mem_dest  = 2'($urandom);
                b.mem_data  = 8'($urandom);
            end
            if (!b.alu_valid || aa) begin
                b.alu_valid = ($urandom_range(0, 1) == 0);
                b.alu_dest  = 2'($urandom);
                b.alu_data  = 8'($urandom);
            end
            b.wb_hold = ($urandom_range(0, 3) == 0);
            #1;
            e_c  = 3'(mq.size());
            e_we = (mq.size() > 0) && !b.wb_hold;
            e_d  = (mq.size() > 0) ? mq[0].d : 2'd0;
            e_v  = (mq.size() > 0) ? mq[0].v : 8'd0;
            e_b  = exp_busy();
            total++;
            if ({b.wb_write_enable, b.wb_dest_reg, b.wb_write_data} !== {e_we, e_d, e_v}) begin
                bad++;
                $display("FAIL rnd_port cyc=%0d got %b/%0d/%h exp %b/%0d/%h",
                    cyc, b.wb_write_enable, b.wb_dest_reg, b.wb_write_data, e_we, e_d, e_v);
            end
            total++;
            if ({b.busy, b.fifo_count} !== {e_b, e_c}) begin
                bad++;
                $display("FAIL rnd_state cyc=%0d got busy=%b cnt=%0d exp %b/%0d",
                    cyc, b.busy, b.fifo_count, e_b, e_c);
            end
            total++;
            if ({b.mem_ready, b.alu_ready} !== {e_c != 3'd4, e_c != 3'd4 && !b.mem_valid}) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d got %b%b exp %b%b", cyc,
                    b.mem_ready, b.alu_ready, e_c != 3'd4, e_c != 3'd4 && !b.mem_valid);
            end
            advance(ma, aa);
        end
        idle_inputs();
        repeat (6) step();
        total++;
        if (b.fifo_count !== 3'(mq.size()) || mq.size() != 0) begin
            bad++; $display("FAIL rnd_final got cnt=%0d exp %0d", b.fifo_count, mq.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_priority();
        test_full();
        test_same_reg();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
